// File: rtl/spike_event_queue_pkg.sv
// Shared definitions for the spike event queue: one-hot step FSM encodings
// and the FIFO depth derived from its log2 parameter.
package spike_event_queue_pkg;

  // One-hot timestep phases
  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_COLLECT = 4'b0010,
    ST_DRAIN   = 4'b0100,
    ST_DONE    = 4'b1000
  } state_t;

  // FIFO depth from its log2
  function automatic int fifo_depth(input int depthbits);
    return 1 << depthbits;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Circular FIFO storage with separate occupancy counter (no pointer extra bit).
// Head is combinational from mem[rd_ptr]; pops on an empty queue are ignored.
// A push while full is accepted only when a valid pop happens in the same cycle.
module sync_fifo_core
  import spike_event_queue_pkg::*;
#(
  parameter int width     = 1,
  parameter int depthbits = 1
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 push,
  input  logic [width-1:0]     push_data,
  input  logic                 pop,
  output logic                 push_accepted,
  output logic [width-1:0]     head,
  output logic [depthbits:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int depth = fifo_depth(depthbits);
  localparam logic [depthbits:0] depth_cnt = (depthbits + 1)'(depth);

  logic [width-1:0]     mem [depth];
  logic [depthbits-1:0] rd_ptr;
  logic [depthbits-1:0] wr_ptr;
  logic                 do_pop;

  assign empty         = (count == '0);
  assign full          = (count == depth_cnt);
  assign do_pop        = pop && !empty;
  // Popping frees a slot in the same edge, so a full queue can still take a push
  assign push_accepted = push && (!full || do_pop);
  assign head          = mem[rd_ptr];

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_accepted) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally; count tracks occupancy so full/empty are unambiguous
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accepted) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_accepted, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spike_event_queue.sv
// Spike event queue: dedups spike tags per timestep and buffers them for the SPU.
// Push-to-visible latency 1 edge; head is combinational from the FIFO.
// No backpressure: duplicates, protocol violations and full-queue spikes are dropped and flagged.
module spike_event_queue
  import spike_event_queue_pkg::*;
#(
  parameter int numneurons = 2,
  parameter int tagbits    = 1,
  parameter int depthbits  = 1
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic                 step_start,
  input  logic                 collect_done,
  input  logic                 spike_valid,
  input  logic [tagbits-1:0]   spike_tag,
  input  logic                 req_deq,
  input  logic                 spu_busy,
  output logic                 fifo_empty,
  output logic [tagbits-1:0]   src_tag_out,
  output logic [depthbits:0]   count,
  output logic                 full,
  output logic                 dup_drop,
  output logic                 overflow,
  output logic                 proto_err,
  output logic                 step_done,
  output logic [3:0]           state
);

  localparam logic [tagbits:0] num_lim = (tagbits + 1)'(numneurons);

  state_t cur_state;
  state_t nxt_state;

  // Sized to the full tag space so any tag indexes it; bits >= numneurons stay 0
  logic [(2**tagbits)-1:0] seen;

  logic in_collect;
  logic tag_ok;
  logic is_seen;
  logic push_req;
  logic push_accepted;
  logic dup_hit;
  logic proto_hit;
  logic overflow_hit;
  logic clear_seen;

  assign state      = cur_state;
  assign in_collect = (cur_state == ST_COLLECT);
  assign tag_ok     = ({1'b0, spike_tag} < num_lim);
  assign is_seen    = seen[spike_tag];
  assign clear_seen = (cur_state == ST_IDLE) && step_start;

  assign push_req     = spike_valid && in_collect && tag_ok && !is_seen;
  assign dup_hit      = spike_valid && in_collect && tag_ok && is_seen;
  assign overflow_hit = push_req && !push_accepted;
  assign proto_hit    = (spike_valid && (!in_collect || !tag_ok)) ||
                        (step_start && (cur_state != ST_IDLE));

  sync_fifo_core #(
    .width     (tagbits),
    .depthbits (depthbits)
  ) u_fifo (
    .clk           (clk),
    .asyn_reset    (asyn_reset),
    .push          (push_req),
    .push_data     (spike_tag),
    .pop           (req_deq),
    .push_accepted (push_accepted),
    .head          (src_tag_out),
    .count         (count),
    .full          (full),
    .empty         (fifo_empty)
  );

  // Step phase register
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Step phase transitions; DRAIN waits for both the queue and the SPU to go quiet
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_IDLE:    if (step_start) nxt_state = ST_COLLECT;
      ST_COLLECT: if (collect_done) nxt_state = ST_DRAIN;
      ST_DRAIN:   if (fifo_empty && !spu_busy) nxt_state = ST_DONE;
      ST_DONE:    nxt_state = ST_IDLE;
      default:    nxt_state = ST_IDLE;
    endcase
  end

  // Per-step dedup bitmap: cleared when a step opens, set on each accepted tag
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      seen <= '0;
    end else if (clear_seen) begin
      seen <= '0;
    end else if (push_accepted) begin
      seen[spike_tag] <= 1'b1;
    end
  end

  // Pulse and sticky status flags; step_done is high exactly while in DONE
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      dup_drop  <= 1'b0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
      step_done <= 1'b0;
    end else begin
      dup_drop  <= dup_hit;
      step_done <= (nxt_state == ST_DONE);
      if (overflow_hit) begin
        overflow <= 1'b1;
      end
      if (proto_hit) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/spike_event_queue.md
Name: spike_event_queue

Overview:
- Spike event queue between the neuron update stage and synaptic_processing_unit2 (SPU).
- Accepts spike source tags from the neuron update stage during a timestep's collect phase and drops duplicate spikes from the same neuron within a step.
- Buffers accepted tags in a circular FIFO and presents the head to the SPU through a fifo_empty/req_deq handshake.
- Signals step_done once the queue is drained and the SPU is idle.

Parameters:
- numneurons, 2, number of neurons; legal tags are 0..numneurons-1.
- tagbits, 1, width of a neuron tag.
- depthbits, 1, log2 of FIFO depth; depth = 2**depthbits.

Ports:
- clk  input  1  clock, rising edge.
- asyn_reset  input  1  reset, asynchronous, active-high.
- step_start  input  1  one-cycle pulse; opens a new timestep and clears the seen bitmap.
- collect_done  input  1  one-cycle pulse; the neuron update stage has finished the step.
- spike_valid  input  1  spike_tag valid this cycle.
- spike_tag  input  tagbits  source neuron of the spike.
- req_deq  input  1  SPU pop request (SPU fetch_src state).
- spu_busy  input  1  SPU busy output.
- fifo_empty  output  1  queue empty (count==0); drives SPU fifo_empty.
- src_tag_out  output  tagbits  head entry, combinational from mem[rd_ptr]; drives SPU src_tag_in.
- count  output  depthbits+1  number of entries held.
- full  output  1  count==depth.
- dup_drop  output  1  registered pulse: a duplicate spike was dropped.
- overflow  output  1  sticky: a spike was dropped because the queue was full.
- proto_err  output  1  sticky: spike outside collect, tag>=numneurons, or step_start outside idle.
- step_done  output  1  one-cycle registered pulse at end of step.
- state  output  4  one-hot FSM state.

Behaviour:
- Reset values (async, all registers):
  - state=IDLE; rd_ptr=wr_ptr=count=0; seen=0.
  - dup_drop=overflow=proto_err=step_done=0.
  - fifo_empty=1, full=0.
  - mem contents are don't-care; src_tag_out is undefined while empty.
- FSM (one-hot, 4'b0001..4'b1000):
  - IDLE: step_start -> COLLECT; clears seen on the same edge.
  - COLLECT: collect_done -> DRAIN.
  - DRAIN: when fifo_empty && !spu_busy -> DONE.
  - DONE: step_done=1 for this one cycle -> IDLE.
  - step_start outside IDLE is ignored and sets proto_err.
- Push rules (evaluated at a rising edge with spike_valid=1):
  - Accepted only in COLLECT. In any other state the spike is dropped and proto_err is set.
  - spike_tag>=numneurons: dropped, proto_err set.
  - seen[spike_tag]=1: dropped, dup_drop=1 next cycle.
  - Else, if not full (or full with a simultaneous valid pop): mem[wr_ptr]<=spike_tag, wr_ptr++, seen[spike_tag]<=1.
  - Else (full, no pop): dropped, overflow set, seen bit left unchanged.
  - A spike arriving in the same cycle as collect_done is still accepted.
- Pop rules:
  - req_deq=1 and count>0: rd_ptr++ at the edge.
  - req_deq with count==0 is ignored; no error, pointers unchanged.
  - The SPU samples src_tag_out on entering fetch_src and pops one cycle later. The head must stay stable from fifo_empty falling until the pop edge, and it does because only pops move rd_ptr.
- Simultaneous push and pop: count is unchanged, both pointers advance. This is legal when full. When empty, only the push occurs.
- Pointers wrap modulo depth (natural depthbits overflow). count is a separate register, so full and empty are distinguished without a pointer extra bit.
- Latency: a push at edge N makes fifo_empty=0 after edge N, so the SPU leaves wait_src at edge N+1.
- Only seen clears between steps. The FIFO itself is not flushed, though it is empty after DRAIN.
- Sticky flags clear only on reset.
- Reset mid-operation: all state is lost immediately and the queue returns to IDLE and empty. The SPU is reset by the same asyn_reset.

Decomposition:
- Shared package/include: one-hot state encodings (IDLE/COLLECT/DRAIN/DONE) and the depth derivation from depthbits.
- One sub-module: sync_fifo_core (storage, pointers, count, full/empty; push/pop inputs).
- The FSM, dedup bitmap and error flags remain in spike_event_queue.

Test Plan:
All cases use numneurons=4, tagbits=2, depthbits=2 unless noted.
- Reset then step_start, spikes 2,0,3 in COLLECT, req_deq pulses -> src_tag_out 2,0,3 in order; count 3->0; fifo_empty returns to 1.
- Spikes 1,1 in the same step -> second dropped, dup_drop pulses once, count=1. After the next step_start, tag 1 is accepted again.
- depthbits=1: spikes 0,1,2 without pops -> full=1 after two; third dropped, overflow=1, count=2, tag 2 not marked seen.
- Full queue, push tag 3 and req_deq in the same cycle -> count stays 2, head advances, tag 3 at tail. Wrap: 6 push/pop cycles with pointers crossing 0 keep FIFO order intact.
- collect_done with 2 entries, SPU model busy for 4 cycles after the last pop -> step_done pulses exactly once, one cycle after fifo_empty && !spu_busy holds in DRAIN. Spike or step_start in DRAIN sets proto_err and is ignored.
- asyn_reset asserted mid-DRAIN with count=2 -> immediately state=4'b0001, count=0, fifo_empty=1, flags 0; no step_done.
